// File: rtl/ControllerDefs.sv
// Shared NAND flash controller definitions: bus widths, host command codes and
// the command scheduler's state and error encodings.
package ControllerDefs;

    localparam int unsigned AddressWidth = 16;
    localparam int unsigned CommandWidth = 3;

    localparam logic [CommandWidth-1:0] host_erase        = 3'd0;
    localparam logic [CommandWidth-1:0] host_program_page = 3'd1;
    localparam logic [CommandWidth-1:0] host_page_read    = 3'd2;

    typedef enum logic [1:0] {
        Sched_Idle,
        Sched_Issue,
        Sched_Wait,
        Sched_Respond
    } sched_states_t;

    localparam logic [1:0] err_none    = 2'd0;
    localparam logic [1:0] err_illegal = 2'd1;
    localparam logic [1:0] err_timeout = 2'd2;

    function automatic logic is_legal_cmd(input logic [CommandWidth-1:0] c);
        return (c == host_erase) || (c == host_program_page) || (c == host_page_read);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request strictly after
// last_grant, wrapping modulo NumReq.
module rr_arbiter #(
    parameter int unsigned NumReq = 4
) (
    input  logic [NumReq-1:0]         req,
    input  logic [$clog2(NumReq)-1:0] last_grant,
    output logic [$clog2(NumReq)-1:0] grant,
    output logic                      any_req
);

    localparam int unsigned IdxW = $clog2(NumReq);

    int              idx;
    logic [IdxW-1:0] sel;

    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int off = 1; off <= int'(NumReq); off++) begin
            idx = int'(last_grant) + off;
            if (idx >= int'(NumReq)) begin
                idx = idx - int'(NumReq);
            end
            sel = idx[IdxW-1:0];
            if (!any_req && req[sel]) begin
                any_req = 1'b1;
                grant   = sel;
            end
        end
    end

endmodule

// File: rtl/nfc_cmd_scheduler.sv
// Round-robin command scheduler: grants one requester at a time, issues its
// command to the NAND controller and returns ack/error after completion or timeout.
module nfc_cmd_scheduler
    import ControllerDefs::*;
#(
    parameter int unsigned NumReq        = 4,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NumReq-1:0]              req,
    input  logic [NumReq*CommandWidth-1:0] cmd_in,
    input  logic [NumReq*AddressWidth-1:0] addr_in,
    output logic [NumReq-1:0]              ack,
    output logic                           err,
    output logic [1:0]                     err_code,
    output logic [$clog2(NumReq)-1:0]      grant_id,
    output logic                           busy,
    output logic                           nfc_start,
    output logic [CommandWidth-1:0]        nfc_command,
    output logic [AddressWidth-1:0]        nfc_rwa,
    input  logic                           nfc_done,
    output logic                           nfc_abort
);

    localparam int unsigned IdxW = $clog2(NumReq);
    localparam int unsigned CntW = $clog2(TimeoutCycles);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    sched_states_t     state_q, state_d;
    logic [IdxW-1:0]   last_grant_q, last_grant_d;
    logic [IdxW-1:0]   grant_q, grant_d;
    logic [CommandWidth-1:0] cmd_q, cmd_d;
    logic [AddressWidth-1:0] addr_q, addr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              abort_q, abort_d;
    logic [1:0]        code_q, code_d;

    logic [IdxW-1:0]   arb_grant;
    logic              arb_any;

    logic [CommandWidth-1:0] cmd_arr  [NumReq];
    logic [AddressWidth-1:0] addr_arr [NumReq];

    for (genvar i = 0; i < int'(NumReq); i++) begin : g_unpack
        assign cmd_arr[i]  = cmd_in[i*CommandWidth +: CommandWidth];
        assign addr_arr[i] = addr_in[i*AddressWidth +: AddressWidth];
    end

    rr_arbiter #(
        .NumReq (NumReq)
    ) u_arb (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .any_req    (arb_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= Sched_Idle;
            last_grant_q <= IdxW'(NumReq - 1);
            grant_q      <= '0;
            cmd_q        <= '0;
            addr_q       <= '0;
            cnt_q        <= '0;
            abort_q      <= 1'b0;
            code_q       <= err_none;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cmd_q        <= cmd_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            abort_q      <= abort_d;
            code_q       <= code_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        cmd_d        = cmd_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        abort_d      = 1'b0;
        code_d       = code_q;
        unique case (state_q)
            Sched_Idle: begin
                if (arb_any) begin
                    grant_d = arb_grant;
                    if (is_legal_cmd(cmd_arr[arb_grant])) begin
                        cmd_d   = cmd_arr[arb_grant];
                        addr_d  = addr_arr[arb_grant];
                        code_d  = err_none;
                        state_d = Sched_Issue;
                    end else begin
                        // Illegal commands never reach the controller bus.
                        code_d  = err_illegal;
                        state_d = Sched_Respond;
                    end
                end
            end
            Sched_Issue: begin
                cnt_d   = '0;
                state_d = Sched_Wait;
            end
            Sched_Wait: begin
                if (abort_q) begin
                    code_d  = err_timeout;
                    state_d = Sched_Respond;
                end else if (nfc_done) begin
                    // Completion on the last watchdog cycle still counts as success.
                    code_d  = err_none;
                    state_d = Sched_Respond;
                end else if (cnt_q == CntLast) begin
                    abort_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            Sched_Respond: begin
                last_grant_d = grant_q;
                state_d      = Sched_Idle;
            end
            default: state_d = Sched_Idle;
        endcase
    end

    always_comb begin
        ack = '0;
        if (state_q == Sched_Respond) begin
            ack[grant_q] = 1'b1;
        end
    end

    assign err         = (state_q == Sched_Respond) && (code_q != err_none);
    assign err_code    = (state_q == Sched_Respond) ? code_q : err_none;
    assign grant_id    = grant_q;
    assign busy        = (state_q != Sched_Idle);
    assign nfc_start   = (state_q == Sched_Issue);
    assign nfc_command = cmd_q;
    assign nfc_rwa     = addr_q;
    assign nfc_abort   = abort_q;

endmodule

// File: tb/tb_nfc_cmd_scheduler.sv
// Self-checking bench for nfc_cmd_scheduler: table of single-command vectors
// plus hand sequences for reset, round-robin, withdrawal and spurious done.
module tb_nfc_cmd_scheduler;

    localparam int NumReq = 4;
    localparam int Tmo    = 16;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [11:0] cmd_in;
    logic [63:0] addr_in;
    logic [3:0]  ack;
    logic        err;
    logic [1:0]  err_code;
    logic [1:0]  grant_id;
    logic        busy;
    logic        nfc_start;
    logic [2:0]  nfc_command;
    logic [15:0] nfc_rwa;
    logic        nfc_done;
    logic        nfc_abort;

    nfc_cmd_scheduler #(
        .NumReq        (NumReq),
        .TimeoutCycles (Tmo)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .cmd_in      (cmd_in),
        .addr_in     (addr_in),
        .ack         (ack),
        .err         (err),
        .err_code    (err_code),
        .grant_id    (grant_id),
        .busy        (busy),
        .nfc_start   (nfc_start),
        .nfc_command (nfc_command),
        .nfc_rwa     (nfc_rwa),
        .nfc_done    (nfc_done),
        .nfc_abort   (nfc_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [2:0]  cmd;
        logic [15:0] addr;
        int          done_dly;   // -1: controller never completes
        int          exp_starts;
        int          exp_aborts;
        logic [3:0]  exp_ack;
        logic        exp_err;
        logic [1:0]  exp_code;
        logic [1:0]  exp_gid;
    } vec_t;

    typedef struct {
        logic [3:0] ack;
        logic       err;
        logic [1:0] code;
        logic [1:0] gid;
    } sb_t;

    sb_t  exp_q [$];
    vec_t tbl [10];

    int pass_cnt  = 0;
    int total_cnt = 0;
    int start_cnt = 0;
    int abort_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (nfc_abort) abort_cnt++;
        if (nfc_start) start_cnt++;
    endtask

    task automatic wait_ack(input int budget, output int lat);
        sb_t e;
        bit  found;
        found = 1'b0;
        lat   = -1;
        for (int i = 0; i < budget && !found; i++) begin
            if (ack != 4'b0) begin
                found = 1'b1;
                lat   = i;
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack", ack, e.ack);
                    chk("err", err, e.err);
                    chk("err_code", err_code, e.code);
                    chk("grant_id", grant_id, e.gid);
                end
            end else begin
                tick();
            end
        end
        if (!found) chk("ack_timeout", 0, 1);
    endtask

    task automatic post_ack_gated();
        tick();
        chk("err_gated", {ack, err, err_code}, 0);
    endtask

    initial begin
        int   lat, n, s0, a0, g;
        bit   bad;
        vec_t v;

        tbl[0] = '{4'b0001, 3'd1, 16'h00A5,  9, 1, 0, 4'b0001, 1'b0, 2'd0, 2'd0};
        tbl[1] = '{4'b0100, 3'd5, 16'h1111,  0, 0, 0, 4'b0100, 1'b1, 2'd1, 2'd2};
        tbl[2] = '{4'b0010, 3'd0, 16'h1234,  1, 1, 0, 4'b0010, 1'b0, 2'd0, 2'd1};
        tbl[3] = '{4'b1000, 3'd2, 16'hFFFF,  3, 1, 0, 4'b1000, 1'b0, 2'd0, 2'd3};
        tbl[4] = '{4'b0100, 3'd7, 16'h0000,  0, 0, 0, 4'b0100, 1'b1, 2'd1, 2'd2};
        tbl[5] = '{4'b0001, 3'd2, 16'h0000, -1, 1, 1, 4'b0001, 1'b1, 2'd2, 2'd0};
        tbl[6] = '{4'b0010, 3'd1, 16'hBEEF, 16, 1, 0, 4'b0010, 1'b0, 2'd0, 2'd1};
        tbl[7] = '{4'b1000, 3'd3, 16'h5555,  0, 0, 0, 4'b1000, 1'b1, 2'd1, 2'd3};
        tbl[8] = '{4'b0110, 3'd1, 16'h0042,  2, 1, 0, 4'b0010, 1'b0, 2'd0, 2'd1};
        tbl[9] = '{4'b0110, 3'd0, 16'h0043,  2, 1, 0, 4'b0100, 1'b0, 2'd0, 2'd2};

        rst      = 1'b1;
        req      = '0;
        cmd_in   = '0;
        addr_in  = '0;
        nfc_done = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_outputs", {ack, err, err_code, grant_id, busy, nfc_start, nfc_command,
                              nfc_rwa, nfc_abort}, 0);

        for (int k = 0; k < 10; k++) begin
            v  = tbl[k];
            s0 = start_cnt;
            a0 = abort_cnt;
            req     = v.req;
            cmd_in  = {4{v.cmd}};
            addr_in = {4{v.addr}};
            exp_q.push_back('{ack: v.exp_ack, err: v.exp_err, code: v.exp_code, gid: v.exp_gid});
            tick();
            req = '0;
            if (v.exp_starts != 0) begin
                chk("start_now", nfc_start, 1);
                chk("nfc_command", nfc_command, v.cmd);
                chk("nfc_rwa", nfc_rwa, v.addr);
                if (v.done_dly >= 0) begin
                    repeat (v.done_dly) tick();
                    chk("held_command", nfc_command, v.cmd);
                    nfc_done = 1'b1;
                    tick();
                    nfc_done = 1'b0;
                end else begin
                    n = 0;
                    while (!nfc_abort && n < 40) begin
                        tick();
                        n++;
                    end
                    chk("abort_cycle", n, Tmo + 1);
                    tick();
                end
            end
            wait_ack(30, lat);
            chk("ack_latency", lat, 0);
            chk("starts", start_cnt - s0, v.exp_starts);
            chk("aborts", abort_cnt - a0, v.exp_aborts);
            post_ack_gated();
        end

        // Reset during WAIT: no ack, no abort, arbitration pointer back to requester 0.
        a0      = abort_cnt;
        req     = 4'b0100;
        cmd_in  = {4{3'd1}};
        addr_in = {4{16'h2222}};
        tick();
        req = '0;
        chk("rst_seq_start", nfc_start, 1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_wait", {ack, err, err_code, grant_id, busy, nfc_start, nfc_command,
                             nfc_rwa, nfc_abort}, 0);
        bad = 1'b0;
        repeat (4) begin
            tick();
            if (ack != 0 || busy) bad = 1'b1;
        end
        chk("rst_no_ack", bad, 0);
        chk("rst_no_abort", abort_cnt - a0, 0);

        // Held requests from all four rotate 0,1,2,3,0.
        req     = 4'b1111;
        cmd_in  = {3'd0, 3'd2, 3'd1, 3'd0};
        addr_in = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
        for (int k = 0; k < 5; k++) begin
            g = k % 4;
            exp_q.push_back('{ack: 4'(1 << g), err: 1'b0, code: 2'd0, gid: 2'(g)});
            n = 0;
            while (!nfc_start && n < 10) begin
                tick();
                n++;
            end
            chk("rr_start_seen", nfc_start, 1);
            chk("rr_grant", grant_id, g);
            chk("rr_cmd", nfc_command, g % 3);
            chk("rr_rwa", nfc_rwa, 16'h0100 + g);
            repeat (3) tick();
            nfc_done = 1'b1;
            tick();
            nfc_done = 1'b0;
            wait_ack(10, lat);
            chk("rr_ack_latency", lat, 0);
            if (k == 4) req = '0;
            post_ack_gated();
        end

        // Withdrawal after grant still completes; stray done in IDLE does nothing.
        s0      = start_cnt;
        req     = 4'b0001;
        cmd_in  = {4{3'd2}};
        addr_in = {4{16'h0777}};
        exp_q.push_back('{ack: 4'b0001, err: 1'b0, code: 2'd0, gid: 2'd0});
        tick();
        req = '0;
        chk("wd_start", start_cnt - s0, 1);
        chk("wd_rwa", nfc_rwa, 16'h0777);
        repeat (7) tick();
        nfc_done = 1'b1;
        tick();
        nfc_done = 1'b0;
        wait_ack(10, lat);
        chk("wd_ack_latency", lat, 0);
        post_ack_gated();

        s0       = start_cnt;
        nfc_done = 1'b1;
        tick();
        nfc_done = 1'b0;
        bad = 1'b0;
        repeat (4) begin
            tick();
            if (ack != 0 || busy) bad = 1'b1;
        end
        chk("spurious_done", bad, 0);
        chk("spurious_no_start", start_cnt - s0, 0);
        chk("sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nfc_cmd_scheduler.md
# nfc_cmd_scheduler

Multi-requester command scheduler in front of the NAND flash controller. It accepts erase, program-page and page-read commands from up to NumReq host-side requesters and grants them round-robin. It issues one command at a time on the controller's command/RWA interface and waits for completion, enforcing a watchdog timeout. It returns a per-requester acknowledge with an error status.

## Interface
Parameters:
- NumReq, 4: number of requesters (2..8).
- TimeoutCycles, 1024: maximum WAIT cycles before abort (≥2).
- AddressWidth, 16: RWA width; taken from the shared package.
- CommandWidth, 3: command width; taken from the shared package.

Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NumReq  per-requester request level.
- cmd_in  in  NumReq*CommandWidth  packed commands; slice i belongs to requester i.
- addr_in  in  NumReq*AddressWidth  packed RWA; slice i belongs to requester i.
- ack  out  NumReq  one-hot, one-cycle completion pulse.
- err  out  1  valid with ack; 1 = command failed.
- err_code  out  2  valid with ack: 0 none, 1 illegal command, 2 timeout.
- grant_id  out  $clog2(NumReq)  index of the requester currently being served.
- busy  out  1  high in every state except IDLE.
- nfc_start  out  1  one-cycle command strobe to the controller.
- nfc_command  out  CommandWidth  command to the controller; held stable from ISSUE through WAIT.
- nfc_rwa  out  AddressWidth  row/word address; held stable from ISSUE through WAIT.
- nfc_done  in  1  controller completion pulse (controller back in Hold).
- nfc_abort  out  1  one-cycle abort pulse on timeout; the controller returns to Hold.

## Operation
- States: IDLE, ISSUE, WAIT, RESPOND.
- IDLE → arbitration:
  - If any req is high, select the first requester searching from last_grant+1 upward, wrapping modulo NumReq.
  - Latch its cmd/addr and grant_id.
  - Legal commands are host_erase=0, host_program_page=1, host_page_read=2. A legal command goes to ISSUE.
  - Any other value goes straight to RESPOND with err=1, err_code=1, and no nfc_start.
- ISSUE: nfc_start=1 for exactly one cycle; clear the watchdog counter; go to WAIT.
- WAIT:
  - The counter increments each cycle.
  - On nfc_done, go to RESPOND with err=0.
  - When the counter reaches TimeoutCycles-1 without nfc_done, pulse nfc_abort and go to RESPOND with err=1, err_code=2.
  - If nfc_done and the timeout occur in the same cycle, done wins: no abort, no error.
- RESPOND: ack[grant_id]=1 for one cycle; last_grant ← grant_id; go to IDLE.
- Round-robin behaviour:
  - A requester holding req high after its ack is treated as a new request, but only after every other pending requester has been served.
  - Two or more simultaneous requests are served in rotating order; no requester is starved.
- Withdrawal: dropping req after the grant does not cancel the command. The command completes and ack still pulses.
- nfc_done outside WAIT is ignored.
- Reset: state IDLE; last_grant=NumReq-1, so requester 0 wins first; counter 0.
  - All outputs reset to 0: ack, err, err_code, grant_id, busy, nfc_start, nfc_command, nfc_rwa, nfc_abort.
- Reset asserted mid-WAIT returns to IDLE next cycle with no ack and no nfc_abort. The controller shares the same rst.

## Timing
- All outputs are registered or decoded from registered state. There is no combinational path from req, cmd_in or nfc_done to outputs.
- Legal command: req sampled at edge 0; nfc_start high in cycle 1.
- Completion: nfc_done sampled at edge k; ack high in cycle k+1.
- Illegal command: req at edge 0; ack with err=1 in cycle 1.
- Timeout: nfc_abort is high in the cycle after the counter reaches TimeoutCycles-1, and ack follows one cycle after nfc_abort.
- Back-to-back: minimum IDLE→IDLE period is 4 cycles, plus controller time.
- err and err_code are valid only while ack is non-zero and are 0 otherwise.

## Structure
- Add to package ControllerDefs:
  - sched_states_t {Sched_Idle, Sched_Issue, Sched_Wait, Sched_Respond}.
  - Error-code constants: err_none=0, err_illegal=1, err_timeout=2.
  - Reuse AddressWidth, CommandWidth and the host_* command codes already defined there.
- One sub-module, rr_arbiter:
  - Inputs: req vector, last_grant.
  - Outputs: grant index and any_req (combinational).
  - Instantiated once.

## Test plan
- After reset, req=4'b0001, cmd=1, addr=16'h00A5 → nfc_start in cycle 1 with nfc_command=1 and nfc_rwa=16'h00A5. nfc_done at cycle 10 → ack=4'b0001 in cycle 11 with err=0.
- req=4'b1111 held with nfc_done returned 3 cycles after each start → acks in order 0,1,2,3,0; grant_id tracks each.
- Requester 2 issues cmd=3'd5 → no nfc_start; ack=4'b0100 one cycle later with err=1, err_code=1.
- TimeoutCycles=16 and nfc_done never asserted → nfc_abort pulses once, then ack with err_code=2. Another test has nfc_done on the exact timeout cycle → no abort, err=0.
- rst asserted during WAIT → next cycle busy=0 and all outputs 0, no ack; the following request is served by requester 0 first.
- req dropped the cycle after grant, nfc_done at cycle 8 → ack still pulses; a spurious nfc_done while IDLE produces no ack.
